// File: rtl/div_pkg.sv
// Shared defaults and record layouts for the divider issue shell.
// No logic: latency and backpressure are defined by the modules that import this package.
package div_pkg;
    localparam int DIV_K      = 32;
    localparam int DIV_NSTAGE = 2;
    localparam int DIV_DEPTH  = 4;
    localparam int DIV_TAGW   = 4;

    typedef struct packed {
        logic [DIV_K-1:0]    q;
        logic [DIV_K-1:0]    r;
        logic [DIV_TAGW-1:0] tag;
        logic                dz;
        logic                ovf;
    } div_res_t;

    typedef struct packed {
        logic                vld;
        logic [DIV_TAGW-1:0] tag;
        logic                dz;
        logic                ovf;
    } div_trk_t;
endpackage

// File: rtl/div_issue_shell_if.sv
// Producer/consumer handshake bundle of the divider shell.
// No latency of its own; in_* side is valid/ready, out_* side is valid/ready.
interface div_issue_shell_if
    import div_pkg::*;
#(
    parameter int K    = DIV_K,
    parameter int TAGW = DIV_TAGW
);
    logic            in_valid;
    logic            in_ready;
    logic [K+31:0]   in_x;
    logic [K-1:0]    in_d;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [K-1:0]    out_q;
    logic [K-1:0]    out_r;
    logic [TAGW-1:0] out_tag;
    logic            out_dz;
    logic            out_ovf;

    modport master (
        output in_valid, in_x, in_d, in_tag, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_tag, out_dz, out_ovf
    );

    modport slave (
        input  in_valid, in_x, in_d, in_tag, out_ready,
        output in_ready, out_valid, out_q, out_r, out_tag, out_dz, out_ovf
    );
endinterface

// File: rtl/div_res_fifo.sv
// In-order result buffer; head visible the cycle after the first push (1-cycle latency).
// Push and pop may share an edge, even when full; caller guarantees no push into a full FIFO.
module div_res_fifo
    import div_pkg::*;
#(
    parameter int  DEPTH = DIV_DEPTH,
    parameter type T     = div_res_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  T              push_dat,
    input  logic          pop_vld,
    output logic          head_vld,
    output T              head_dat,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_vld) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop_vld) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_vld = (count != '0);
    assign head_dat = mem[rptr];
endmodule

// File: rtl/div_issue_shell.sv
// Valid/ready shell around a fixed-latency divider: tags ops, flags divide-by-zero/overflow, buffers results.
// Fire to out_valid is NSTAGE+1 edges; credits throttle in_ready so a stalled consumer never loses a result.
module div_issue_shell
    import div_pkg::*;
#(
    parameter int K      = DIV_K,
    parameter int NSTAGE = DIV_NSTAGE,
    parameter int DEPTH  = DIV_DEPTH,
    parameter int TAGW   = DIV_TAGW
) (
    input  logic           clk,
    input  logic           rst,
    div_issue_shell_if.slave io,
    output logic [K+31:0]  div_x,
    output logic [K-1:0]   div_d,
    output logic           div_rstn,
    input  logic [K-1:0]   div_q,
    input  logic [K-1:0]   div_r
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [K-1:0]    q;
        logic [K-1:0]    r;
        logic [TAGW-1:0] tag;
        logic            dz;
        logic            ovf;
    } res_t;

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] tag;
        logic            dz;
        logic            ovf;
    } trk_t;

    logic          live;
    logic [CW-1:0] credits;
    logic          fire;
    logic          pop;
    trk_t          trk [NSTAGE+1];
    trk_t          trk_in;
    res_t          push_dat;
    res_t          head;
    logic          head_vld;
    logic [CW-1:0] fifo_count;
    int            occupancy;

    assign div_rstn    = ~rst;
    assign io.in_ready = live && (credits != '0);
    assign fire        = io.in_valid && io.in_ready;
    assign pop         = head_vld && io.out_ready;

    always_comb begin
        trk_in     = '0;
        trk_in.vld = fire;
        trk_in.tag = io.in_tag;
        trk_in.dz  = (io.in_d == '0);
        trk_in.ovf = (io.in_d != '0) && (io.in_x[K+31:32] >= io.in_d);
    end

    // The divider cannot stall, so the tracker shifts every cycle and its last slot lines up with div_q/div_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live    <= 1'b0;
            credits <= CW'(DEPTH);
            div_x   <= '0;
            div_d   <= '0;
            for (int i = 0; i <= NSTAGE; i++) begin
                trk[i] <= '0;
            end
        end else begin
            live <= 1'b1;
            if (fire) begin
                div_x <= io.in_x;
                div_d <= io.in_d;
            end
            trk[0] <= trk_in;
            for (int i = 1; i <= NSTAGE; i++) begin
                trk[i] <= trk[i-1];
            end
            case ({fire, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_comb begin
        push_dat     = '0;
        push_dat.q   = div_q;
        push_dat.r   = div_r;
        push_dat.tag = trk[NSTAGE].tag;
        push_dat.dz  = trk[NSTAGE].dz;
        push_dat.ovf = trk[NSTAGE].ovf;
    end

    div_res_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (trk[NSTAGE].vld),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .head_vld (head_vld),
        .head_dat (head),
        .count    (fifo_count)
    );

    assign io.out_valid = head_vld;
    assign io.out_q     = head.q;
    assign io.out_r     = head.r;
    assign io.out_tag   = head.tag;
    assign io.out_dz    = head.dz;
    assign io.out_ovf   = head.ovf;

    // Every credit is either free, riding the tracker, or parked in the FIFO.
    always_comb begin
        occupancy = int'(credits) + int'(fifo_count);
        for (int i = 0; i <= NSTAGE; i++) begin
            occupancy = occupancy + int'(trk[i].vld);
        end
    end

    assert property (@(posedge clk) disable iff (rst) occupancy == DEPTH);
endmodule

// File: tb/tb_div_issue_shell.sv
// Bench for div_issue_shell: pipelined divider stand-in, fixed vector table and a time-stamped result queue.
module tb_div_issue_shell;
    localparam int NSTAGE = 2;
    // One entry beyond NSTAGE+2 covers the pop-to-credit turnaround so back-to-back issue never stalls.
    localparam int DEPTH  = NSTAGE + 3;

    logic        clk;
    logic        rst;
    logic [63:0] div_x;
    logic [31:0] div_d;
    logic        div_rstn;
    logic [31:0] div_q;
    logic [31:0] div_r;

    div_issue_shell_if #(.K(32), .TAGW(4)) bus ();

    div_issue_shell #(.K(32), .NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (bus),
        .div_x    (div_x),
        .div_d    (div_d),
        .div_rstn (div_rstn),
        .div_q    (div_q),
        .div_r    (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] px [NSTAGE];
    logic [31:0] pd [NSTAGE];

    always_ff @(posedge clk or negedge div_rstn) begin
        if (!div_rstn) begin
            for (int i = 0; i < NSTAGE; i++) begin
                px[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            px[0] <= div_x;
            pd[0] <= div_d;
            for (int i = 1; i < NSTAGE; i++) begin
                px[i] <= px[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_comb begin
        div_q = '1;
        div_r = px[NSTAGE-1][31:0];
        if (pd[NSTAGE-1] != 32'd0) begin
            div_q = 32'(px[NSTAGE-1] / {32'd0, pd[NSTAGE-1]});
            div_r = 32'(px[NSTAGE-1] % {32'd0, pd[NSTAGE-1]});
        end
    end

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dz;
        logic        ovf;
        int          vis;
    } exp_t;

    typedef struct {
        logic [63:0] x;
        logic [31:0] d;
        logic [3:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
        logic        chk_qr;
    } vec_t;

    exp_t        sb[$];
    int          pass_cnt;
    int          total_cnt;
    int          cyc;
    bit          live;
    bit          fired;
    bit          got_pop;
    logic [31:0] got_q;
    logic [31:0] got_r;
    logic [3:0]  got_tag;
    logic        got_dz;
    logic        got_ovf;

    function automatic exp_t ref_op(input logic [63:0] x, input logic [31:0] d,
                                    input logic [3:0] tag, input int vis);
        exp_t e;
        e.tag = tag;
        e.vis = vis;
        e.dz  = (d == 32'd0);
        e.ovf = (d != 32'd0) && (x[63:32] >= d);
        if (d == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = x[31:0];
        end else begin
            e.q = 32'(x / {32'd0, d});
            e.r = 32'(x % {32'd0, d});
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: drive, check against the queue model at negedge, advance the model after the edge.
    task automatic cycle(input logic r, input logic v, input logic [63:0] x,
                         input logic [31:0] d, input logic [3:0] tag, input logic ordy);
        bit exp_rdy;
        bit exp_vld;
        bit pop;
        rst           = r;
        bus.in_valid  = v;
        bus.in_x      = x;
        bus.in_d      = d;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        if (r) begin
            sb.delete();
            live = 1'b0;
        end
        exp_rdy = live && !r && (sb.size() < DEPTH);
        exp_vld = !r && (sb.size() > 0) && (sb[0].vis <= cyc);
        @(negedge clk);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, exp_vld);
        pop     = exp_vld && ordy;
        got_pop = pop;
        if (pop) begin
            got_q   = bus.out_q;
            got_r   = bus.out_r;
            got_tag = bus.out_tag;
            got_dz  = bus.out_dz;
            got_ovf = bus.out_ovf;
            check("sb_tag", bus.out_tag, sb[0].tag);
            check("sb_dz", bus.out_dz, sb[0].dz);
            check("sb_ovf", bus.out_ovf, sb[0].ovf);
            if (!sb[0].ovf) begin
                check("sb_q", bus.out_q, sb[0].q);
                check("sb_r", bus.out_r, sb[0].r);
            end
        end
        fired = v && exp_rdy;
        @(posedge clk);
        #1;
        if (pop) void'(sb.pop_front());
        if (fired) sb.push_back(ref_op(x, d, tag, cyc + NSTAGE + 2));
        cyc++;
        live = !r;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 64'd0, 32'd0, 4'd0, ordy);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        if (sb.size() > 0) fail("drain");
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, {32'd0, 32'(base + i)}, 32'd7, 4'(i), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   fires;
        int   n;
        logic [31:0] rd;
        logic [31:0] xh;

        vecs[0] = '{64'd100, 32'd7, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_1234, 32'd0, 4'd5, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{64'h0000_0009_0000_0000, 32'd9, 4'd6, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{64'h0000_0008_0000_0000, 32'd9, 4'd7, 32'd3817748707, 32'd5, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{64'd0, 32'd5, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 32'd1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{64'h0000_0004_0000_0000, 32'd5, 4'd10, 32'd3435973836, 32'd4, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{64'h0000_0005_0000_ABCD, 32'd0, 4'd11, 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1};

        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        live      = 1'b0;
        rst       = 1'b1;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'd0, 32'd0, 4'd0, 1'b1);
        check("rst_div_x", div_x, 64'd0);
        check("rst_div_d", div_d, 64'd0);
        check("rst_div_rstn", div_rstn, 64'd0);
        idle(1'b1);
        check("div_rstn_released", div_rstn, 64'd1);

        // Fixed vectors, one op at a time, including divide-by-zero and the overflow boundary.
        foreach (vecs[k]) begin
            n = 0;
            do begin
                cycle(1'b0, 1'b1, vecs[k].x, vecs[k].d, vecs[k].tag, 1'b1);
                n++;
            end while (!fired && n < 10);
            if (!fired) fail("vec_accept");
            check("vec_div_x", div_x, vecs[k].x);
            check("vec_div_d", div_d, {32'd0, vecs[k].d});
            n       = 0;
            got_pop = 1'b0;
            while (!got_pop && n < 20) begin
                idle(1'b1);
                n++;
            end
            if (!got_pop) begin
                fail("vec_result");
            end else begin
                check("vec_latency", 64'(n - 1), 64'(NSTAGE + 1));
                check("vec_tag", got_tag, vecs[k].tag);
                check("vec_dz", got_dz, vecs[k].dz);
                check("vec_ovf", got_ovf, vecs[k].ovf);
                if (vecs[k].chk_qr) begin
                    check("vec_q", got_q, vecs[k].q);
                    check("vec_r", got_r, vecs[k].r);
                end
            end
        end

        // Back-to-back random issue with a free-running consumer.
        fires = 0;
        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            if (rd == 32'd0) rd = 32'd1;
            xh = $urandom_range(rd - 1, 0);
            cycle(1'b0, 1'b1, {xh, 32'($urandom)}, rd, 4'($urandom), 1'b1);
            if (fired) fires++;
        end
        check("b2b_fires", 64'(fires), 64'd1000);
        drain();

        // Consumer stalled: credits run out after DEPTH fires, one pop reopens the input.
        fill(DEPTH, 200);
        check("full_in_ready", bus.in_ready, 64'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 64'd55, 32'd3, 4'd15, 1'b0);
        idle(1'b1);
        check("pop_in_ready", bus.in_ready, 64'd1);
        drain();

        // Random traffic with random stalls, zero divisors and overflowing dividends.
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            xh = ($urandom_range(0, 1) == 0 || rd == 32'd0) ? $urandom : $urandom_range(rd - 1, 0);
            cycle(1'b0, ($urandom_range(0, 3) != 0), {xh, 32'($urandom)}, rd, 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset with ops both in the divider pipe and buffered: nothing may resurface afterwards.
        fill(DEPTH, 300);
        cycle(1'b1, 1'b0, 64'd0, 32'd0, 4'd0, 1'b0);
        check("midrst_out_valid", bus.out_valid, 64'd0);
        check("midrst_div_x", div_x, 64'd0);
        cycle(1'b1, 1'b0, 64'd0, 32'd0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);
        fill(DEPTH, 400);
        check("postrst_full", bus.in_ready, 64'd0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
